// File: rtl/ne_fp_e_align_pkg.sv
// Shared mode encoding, exponent constants and mode decode for the
// dot-product exponent-align pipeline.
package ne_fp_e_align_pkg;

    localparam int MODE_BYP_BIT  = 0;
    localparam int MODE_FP8_BIT  = 1;
    localparam int MODE_TF32_BIT = 2;
    localparam int MODE_TEST_BIT = 3;

    localparam int BIAS_TF32    = -252;
    localparam int BIAS_FP8     = -28;
    localparam int TEST_EMAX    = 45;
    localparam int LIM_TF32_DEF = 26;
    localparam int LIM_FP8_DEF  = 25;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_FP8    = 2'd1,
        MODE_TF32   = 2'd2,
        MODE_TEST   = 2'd3
    } mode_e;

    // Highest set bit wins; an all-zero op_mode falls through to bypass.
    function automatic mode_e decode_mode(input logic [3:0] op_mode);
        mode_e m;
        if (op_mode[MODE_TEST_BIT]) begin
            m = MODE_TEST;
        end else if (op_mode[MODE_TF32_BIT]) begin
            m = MODE_TF32;
        end else if (op_mode[MODE_FP8_BIT]) begin
            m = MODE_FP8;
        end else begin
            m = MODE_BYPASS;
        end
        return m;
    endfunction

endpackage

// File: rtl/ne_fp_e_align_pipe_if.sv
// Beat-level handshake and data bundle between the exponent-align pipe and
// its producer/consumer.
interface ne_fp_e_align_pipe_if #(
    parameter int LANES = 16,
    parameter int EW    = 9,
    parameter int DW    = 6
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            op_mode;
    logic [LANES*EW-1:0]   a_e;
    logic [LANES*EW-1:0]   b_e;
    logic                  out_valid;
    logic                  out_ready;
    logic [EW-1:0]         e_max;
    logic [LANES*DW-1:0]   a_e_sub;
    logic [LANES*DW-1:0]   b_e_sub;
    logic [LANES-1:0]      a_e_ovf;
    logic [LANES-1:0]      b_e_ovf;

    modport master (
        output in_valid, op_mode, a_e, b_e, out_ready,
        input  in_ready, out_valid, e_max, a_e_sub, b_e_sub, a_e_ovf, b_e_ovf
    );

    modport slave (
        input  in_valid, op_mode, a_e, b_e, out_ready,
        output in_ready, out_valid, e_max, a_e_sub, b_e_sub, a_e_ovf, b_e_ovf
    );

endinterface

// File: rtl/ne_fp_e_max_tree.sv
// Combinational signed maximum of N packed W-bit values.
module ne_fp_e_max_tree #(
    parameter int N = 4,
    parameter int W = 9
) (
    input  logic [N*W-1:0] in_i,
    output logic [W-1:0]   max_o
);

    logic [W-1:0] best_s;

    // Linear scan; N is small at every instantiation site.
    always_comb begin
        best_s = in_i[W-1:0];
        for (int i = 1; i < N; i++) begin
            if ($signed(in_i[i*W +: W]) > $signed(best_s)) begin
                best_s = in_i[i*W +: W];
            end else begin
                best_s = best_s;
            end
        end
    end

    assign max_o = best_s;

endmodule

// File: rtl/ne_fp_e_align_pipe.sv
// Three-stage back-pressured exponent-align pipe: group maxima, final e_max
// with per-lane differences, then saturated diffs and overflow flags.
module ne_fp_e_align_pipe
    import ne_fp_e_align_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int EW       = 9,
    parameter int DW       = 6,
    parameter int LIM_TF32 = LIM_TF32_DEF,
    parameter int LIM_FP8  = LIM_FP8_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    ne_fp_e_align_pipe_if.slave bus
);

    localparam int G   = LANES / 4;
    localparam int DWE = EW + 1;
    localparam logic [EW-1:0] MIN_E = {1'b1, {(EW-1){1'b0}}};

    // Stage 1 state
    logic                s1_valid_q;
    mode_e               s1_mode_q;
    logic [EW-1:0]       s1_bias_q;
    logic [LANES*EW-1:0] s1_a_q;
    logic [LANES*EW-1:0] s1_b_q;
    logic [G*EW-1:0]     s1_ga_q;
    logic [G*EW-1:0]     s1_gb_q;
    // Stage 2 state
    logic                 s2_valid_q;
    mode_e                s2_mode_q;
    logic [EW-1:0]        s2_emax_q;
    logic [LANES*DWE-1:0] s2_a_diff_q;
    logic [LANES*DWE-1:0] s2_b_diff_q;
    // Output registers
    logic                out_valid_q;
    logic [EW-1:0]       e_max_q;
    logic [LANES*DW-1:0] a_sub_q;
    logic [LANES*DW-1:0] b_sub_q;
    logic [LANES-1:0]    a_ovf_q;
    logic [LANES-1:0]    b_ovf_q;

    logic adv_s;
    assign adv_s        = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv_s;

    // ---------------- Stage 1 combinational ----------------
    mode_e               s1_mode_d;
    logic [EW-1:0]       s1_bias_d;
    logic [LANES*EW-1:0] grp_a_in_s;
    logic [LANES*EW-1:0] grp_b_in_s;
    logic [G*EW-1:0]     s1_ga_d;
    logic [G*EW-1:0]     s1_gb_d;

    assign s1_mode_d  = decode_mode(bus.op_mode);
    assign grp_a_in_s = (s1_mode_d == MODE_TEST) ? '0 : bus.a_e;
    assign grp_b_in_s = (s1_mode_d == MODE_TEST) ? '0 : bus.b_e;

    // Mode bias that the reduction must beat.
    always_comb begin
        case (s1_mode_d)
            MODE_TF32: s1_bias_d = EW'(BIAS_TF32);
            MODE_FP8:  s1_bias_d = EW'(BIAS_FP8);
            default:   s1_bias_d = MIN_E;
        endcase
    end

    for (genvar g = 0; g < G; g++) begin : g_grp
        ne_fp_e_max_tree #(.N(4), .W(EW)) u_max_a (
            .in_i  (grp_a_in_s[g*4*EW +: 4*EW]),
            .max_o (s1_ga_d[g*EW +: EW])
        );
        ne_fp_e_max_tree #(.N(4), .W(EW)) u_max_b (
            .in_i  (grp_b_in_s[g*4*EW +: 4*EW]),
            .max_o (s1_gb_d[g*EW +: EW])
        );
    end

    // ---------------- Stage 2 combinational ----------------
    logic [(2*G+1)*EW-1:0] red_in_s;
    logic [EW-1:0]         red_max_s;
    logic [EW-1:0]         s2_emax_d;
    logic [LANES*DWE-1:0]  s2_a_diff_d;
    logic [LANES*DWE-1:0]  s2_b_diff_d;

    // b groups only take part in FP8; elsewhere they are pinned to the floor.
    assign red_in_s = {s1_bias_q, ((s1_mode_q == MODE_FP8) ? s1_gb_q : {G{MIN_E}}), s1_ga_q};

    ne_fp_e_max_tree #(.N(2*G+1), .W(EW)) u_max_red (
        .in_i  (red_in_s),
        .max_o (red_max_s)
    );

    // Final e_max and sign-extended per-lane differences.
    always_comb begin
        s2_a_diff_d = '0;
        s2_b_diff_d = '0;
        case (s1_mode_q)
            MODE_TEST:           s2_emax_d = EW'(TEST_EMAX);
            MODE_TF32, MODE_FP8: s2_emax_d = red_max_s;
            default:             s2_emax_d = '0;
        endcase
        for (int i = 0; i < LANES; i++) begin
            s2_a_diff_d[i*DWE +: DWE] = {s2_emax_d[EW-1], s2_emax_d}
                                      - {s1_a_q[i*EW+EW-1], s1_a_q[i*EW +: EW]};
            s2_b_diff_d[i*DWE +: DWE] = {s2_emax_d[EW-1], s2_emax_d}
                                      - {s1_b_q[i*EW+EW-1], s1_b_q[i*EW +: EW]};
        end
    end

    // ---------------- Stage 3 combinational ----------------
    // Returns {ovf, sub}; a negative diff passes its low bits through unflagged.
    function automatic logic [DW:0] sat_lane(input logic [DWE-1:0] diff,
                                             input logic           mode_ok,
                                             input int             lim);
        logic ovf;
        logic big;
        ovf = mode_ok & ~diff[DWE-1] & (diff >= DWE'(lim));
        big = ~diff[DWE-1] & (|diff[DWE-2:DW]);
        return {ovf, ((ovf | big) ? {DW{1'b1}} : diff[DW-1:0])};
    endfunction

    logic a_ok_s;
    logic b_ok_s;
    logic a_on_s;
    logic b_on_s;
    int   lim_a_s;

    // Per-mode enables for flags and sub outputs.
    always_comb begin
        a_ok_s  = 1'b0;
        b_ok_s  = 1'b0;
        a_on_s  = 1'b0;
        b_on_s  = 1'b0;
        lim_a_s = LIM_FP8;
        case (s2_mode_q)
            MODE_TF32: begin
                a_ok_s  = 1'b1;
                a_on_s  = 1'b1;
                lim_a_s = LIM_TF32;
            end
            MODE_FP8: begin
                a_ok_s = 1'b1;
                b_ok_s = 1'b1;
                a_on_s = 1'b1;
                b_on_s = 1'b1;
            end
            MODE_TEST: begin
                a_on_s = 1'b1;
                b_on_s = 1'b1;
            end
            default: begin
                a_on_s = 1'b0;
            end
        endcase
    end

    logic [LANES*DW-1:0] a_sub_d;
    logic [LANES*DW-1:0] b_sub_d;
    logic [LANES-1:0]    a_ovf_d;
    logic [LANES-1:0]    b_ovf_d;

    // Saturation and gating of every lane.
    always_comb begin
        logic [DW:0] a_res;
        logic [DW:0] b_res;
        a_res   = '0;
        b_res   = '0;
        a_sub_d = '0;
        b_sub_d = '0;
        a_ovf_d = '0;
        b_ovf_d = '0;
        for (int i = 0; i < LANES; i++) begin
            a_res = sat_lane(s2_a_diff_q[i*DWE +: DWE], a_ok_s, lim_a_s);
            b_res = sat_lane(s2_b_diff_q[i*DWE +: DWE], b_ok_s, LIM_FP8);
            a_sub_d[i*DW +: DW] = a_on_s ? a_res[DW-1:0] : {DW{1'b0}};
            b_sub_d[i*DW +: DW] = b_on_s ? b_res[DW-1:0] : {DW{1'b0}};
            a_ovf_d[i]          = a_res[DW];
            b_ovf_d[i]          = b_res[DW];
        end
    end

    // All stages move together on adv; a stall freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_BYPASS;
            s1_bias_q   <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ga_q     <= '0;
            s1_gb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= MODE_BYPASS;
            s2_emax_q   <= '0;
            s2_a_diff_q <= '0;
            s2_b_diff_q <= '0;
            out_valid_q <= 1'b0;
            e_max_q     <= '0;
            a_sub_q     <= '0;
            b_sub_q     <= '0;
            a_ovf_q     <= '0;
            b_ovf_q     <= '0;
        end else if (adv_s) begin
            s1_valid_q  <= bus.in_valid;
            s1_mode_q   <= s1_mode_d;
            s1_bias_q   <= s1_bias_d;
            s1_a_q      <= bus.a_e;
            s1_b_q      <= bus.b_e;
            s1_ga_q     <= s1_ga_d;
            s1_gb_q     <= s1_gb_d;
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_emax_q   <= s2_emax_d;
            s2_a_diff_q <= s2_a_diff_d;
            s2_b_diff_q <= s2_b_diff_d;
            out_valid_q <= s2_valid_q;
            e_max_q     <= s2_emax_q;
            a_sub_q     <= a_sub_d;
            b_sub_q     <= b_sub_d;
            a_ovf_q     <= a_ovf_d;
            b_ovf_q     <= b_ovf_d;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.e_max     = e_max_q;
    assign bus.a_e_sub   = a_sub_q;
    assign bus.b_e_sub   = b_sub_q;
    assign bus.a_e_ovf   = a_ovf_q;
    assign bus.b_e_ovf   = b_ovf_q;

endmodule

// File: tb/tb_ne_fp_e_align_pipe.sv
// Scoreboard bench for ne_fp_e_align_pipe: directed beats push hand-computed
// expectations; an independent monitor pops and compares on each output beat.
module tb_ne_fp_e_align_pipe;

    localparam int LANES = 16;
    localparam int EW    = 9;
    localparam int DW    = 6;

    localparam logic [3:0] M_BYP  = 4'b0001;
    localparam logic [3:0] M_FP8  = 4'b0010;
    localparam logic [3:0] M_TF32 = 4'b0100;
    localparam logic [3:0] M_TEST = 4'b1000;

    typedef struct {
        logic [EW-1:0]       emax;
        logic [LANES*DW-1:0] asub;
        logic [LANES*DW-1:0] bsub;
        logic [LANES-1:0]    aovf;
        logic [LANES-1:0]    bovf;
        int                  acc;
        bit                  lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_acc  = 0;
    exp_t exp_q[$];

    ne_fp_e_align_pipe_if #(.LANES(LANES), .EW(EW), .DW(DW)) bus ();

    ne_fp_e_align_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one beat (default lane values plus one special lane) and queue its expectation.
    task automatic send(input logic [3:0] m,
                        input int a_def, input int a_idx, input int a_val,
                        input int b_def, input int b_idx, input int b_val,
                        input int e_emax,
                        input int ea_d, input int ea_s, input bit oa_d, input bit oa_s,
                        input int eb_d, input int eb_s, input bit ob_d, input bit ob_s,
                        input bit lat);
        exp_t e;
        int   w;
        @(negedge clk);
        bus.op_mode = m;
        for (int i = 0; i < LANES; i++) begin
            bus.a_e[i*EW +: EW]  = (i == a_idx) ? EW'(a_val) : EW'(a_def);
            bus.b_e[i*EW +: EW]  = (i == b_idx) ? EW'(b_val) : EW'(b_def);
            e.asub[i*DW +: DW]   = (i == a_idx) ? DW'(ea_s) : DW'(ea_d);
            e.bsub[i*DW +: DW]   = (i == b_idx) ? DW'(eb_s) : DW'(eb_d);
            e.aovf[i]            = (i == a_idx) ? oa_s : oa_d;
            e.bovf[i]            = (i == b_idx) ? ob_s : ob_d;
        end
        e.emax = EW'(e_emax);
        e.lat  = lat;
        bus.in_valid = 1'b1;
        #1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck low, beat dropped");
            bus.in_valid = 1'b0;
        end else begin
            e.acc = cyc;
            exp_q.push_back(e);
            @(posedge clk);
            n_acc++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: handshake rule, stall stability and in-order scoreboard pops.
    initial begin : monitor
        logic [255:0] snap;
        bit           stall_prev;
        exp_t         e;
        stall_prev = 1'b0;
        snap       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("in_ready_rule", 256'(bus.in_ready), 256'(!bus.out_valid || bus.out_ready));
                if (stall_prev) begin
                    chk("stall_stable", 256'({bus.out_valid, bus.e_max, bus.a_e_sub, bus.b_e_sub,
                                              bus.a_e_ovf, bus.b_e_ovf}), snap);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("e_max", 256'(bus.e_max), 256'(e.emax));
                        chk("a_e_sub", 256'(bus.a_e_sub), 256'(e.asub));
                        chk("b_e_sub", 256'(bus.b_e_sub), 256'(e.bsub));
                        chk("a_e_ovf", 256'(bus.a_e_ovf), 256'(e.aovf));
                        chk("b_e_ovf", 256'(bus.b_e_ovf), 256'(e.bovf));
                        if (e.lat) chk("latency", 256'(cyc - e.acc), 256'(3));
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                snap = 256'({bus.out_valid, bus.e_max, bus.a_e_sub, bus.b_e_sub,
                              bus.a_e_ovf, bus.b_e_ovf});
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op_mode   = 4'b0000;
        bus.a_e       = '0;
        bus.b_e       = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_outputs", 256'({bus.e_max, bus.a_e_sub, bus.b_e_sub, bus.a_e_ovf, bus.b_e_ovf}), 256'(0));
        rst_n = 1'b1;

        // m, a_def,a_idx,a_val, b_def,b_idx,b_val, emax, ea_d,ea_s,oa_d,oa_s, eb_d,eb_s,ob_d,ob_s, lat
        send(M_FP8,     0, 0,    0,    0, 0,    5,    5,  5,  5, 0, 0,  5,  0, 0, 0, 1);
        send(M_TF32, -200, 3,  100,    0, 0,    0,  100, 63,  0, 1, 0,  0,  0, 0, 0, 1);
        send(M_TF32, -256, 0, -256,    0, 0,    0, -252,  4,  4, 0, 0,  0,  0, 0, 0, 1);
        send(M_TEST,   40, 0,   40,    0, 5,   50,   45,  5,  5, 0, 0, 45, 59, 0, 0, 1);
        send(M_FP8,     0, 7,  -25,  -24, 2,    0,    0,  0, 63, 0, 1, 24,  0, 0, 0, 1);
        send(M_TF32,   10, 15, -16,  100, 0,  100,   10,  0, 63, 0, 1,  0,  0, 0, 0, 1);
        send(M_TF32,   10, 0,  -15,  100, 0,  100,   10,  0, 25, 0, 0,  0,  0, 0, 0, 1);
        send(M_BYP,     7, 0,    7,    3, 0,    3,    0,  0,  0, 0, 0,  0,  0, 0, 0, 1);
        send(4'b0000,   7, 1, -100,    3, 0,    3,    0,  0,  0, 0, 0,  0,  0, 0, 0, 1);
        send(4'b0110,  20, 0,   20,   30, 0,   30,   20,  0,  0, 0, 0,  0,  0, 0, 0, 1);
        send(4'b1111,  45, 4,  -30,   44, 0,   44,   45,  0, 63, 0, 0,  1,  1, 0, 0, 1);
        send(M_FP8,   255, 0,  255, -256, 0, -256,  255,  0,  0, 0, 0, 63, 63, 1, 1, 1);
        send(M_FP8,   -50, 0,  -50,  -40, 0,  -40,  -28, 22, 22, 0, 0, 12, 12, 0, 0, 1);
        idle();
        repeat (6) @(negedge clk);

        // Back-pressure: consumer stalls while five beats are offered.
        bus.out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(M_FP8, k, 0, k, 0, 0, 0, k, 0, 0, 0, 0, k, k, 0, 0, 0);
            end
            begin
                repeat (7) @(negedge clk);
                chk("bp_held_beats", 256'(n_acc), 256'(3));
                chk("bp_in_ready_low", 256'(bus.in_ready), 256'(0));
                bus.out_ready = 1'b1;
            end
        join
        idle();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("bp_drained", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset with one beat presented and two in flight.
        for (int k = 1; k <= 3; k++)
            send(M_FP8, 9, 0, 9, 0, 0, 0, 9, 0, 0, 0, 0, 9, 9, 0, 0, 1);
        #1;
        chk("pre_rst_out_valid", 256'(bus.out_valid), 256'(1));
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("async_rst_outputs", 256'({bus.e_max, bus.a_e_sub, bus.b_e_sub, bus.a_e_ovf, bus.b_e_ovf}), 256'(0));
        chk("async_rst_in_ready", 256'(bus.in_ready), 256'(1));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(M_FP8, 3, 0, 3, 0, 0, 0, 3, 0, 0, 0, 0, 3, 3, 0, 0, 1);
        idle();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("final_drained", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
